// File: rtl/reg_file_sb.sv
// Register file with an issue/write-back scoreboard and a post-reset clear sweep.
// Latency: reads, write bypass and busy flags are combinational; writes, issues and sweep steps commit on the CLOCK rising edge.
// Backpressure: none on WRITE/ISSUE, which are dropped while READY=0; READY rises DEPTH edges after the last RESET-high edge.
//
// Ports:
//   CLOCK, RESET        single clock, synchronous active-high reset
//   WRITE/INADDRESS/IN  write-back port (also clears the destination busy bit)
//   ISSUE/ISSUEADDR     marks a destination register busy until written back
//   RDADDR/RDDATA       N_RD packed combinational read ports, port p at [p*W +: W]
//   RDBUSY              per-port "operand not yet written back" flag
//   READY               clear sweep finished, file usable
module reg_file_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_RD     = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                     CLOCK,
   input  logic                     RESET,
   input  logic                     WRITE,
   input  logic [ADDR_W-1:0]        INADDRESS,
   input  logic [DATA_W-1:0]        IN,
   input  logic                     ISSUE,
   input  logic [ADDR_W-1:0]        ISSUEADDR,
   input  logic [N_RD*ADDR_W-1:0]   RDADDR,
   output logic [N_RD*DATA_W-1:0]   RDDATA,
   output logic [N_RD-1:0]          RDBUSY,
   output logic                     READY
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              ready_q, ready_d;

   logic wr_en;
   logic iss_en;

   // Register 0 is hard-wired when ZERO_REG is set, so it can never be written or become busy.
   always_comb begin
      wr_en  = WRITE & ready_q & ~((ZERO_REG != 0) && (INADDRESS == '0));
      iss_en = ISSUE & ready_q & ~((ZERO_REG != 0) && (ISSUEADDR == '0));
   end

   always_comb begin
      mem_d   = mem_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      ready_d = ready_q;
      if (!ready_q) begin
         // Clear sweep: one register per edge, ready after the last index.
         mem_d[ptr_q] = '0;
         ptr_d        = ptr_q + 1'b1;
         if (ptr_q == '1) begin
            ready_d = 1'b1;
         end
      end else begin
         if (wr_en) begin
            mem_d[INADDRESS]  = IN;
            busy_d[INADDRESS] = 1'b0;
         end
         // Applied after the write-back clear so a new producer to the same index wins.
         if (iss_en) begin
            busy_d[ISSUEADDR] = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         ptr_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= '0;
      end else begin
         mem_q   <= mem_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         ready_q <= ready_d;
      end
   end

   // Read ports: a same-cycle write-back to the read index is forwarded and reports not busy.
   always_comb begin
      RDDATA = '0;
      RDBUSY = '0;
      for (int p = 0; p < N_RD; p++) begin
         logic [ADDR_W-1:0] ra;
         ra = RDADDR[p*ADDR_W +: ADDR_W];
         if (ready_q && !((ZERO_REG != 0) && (ra == '0))) begin
            if (wr_en && (INADDRESS == ra)) begin
               RDDATA[p*DATA_W +: DATA_W] = IN;
               RDBUSY[p]                  = 1'b0;
            end else begin
               RDDATA[p*DATA_W +: DATA_W] = mem_q[ra];
               RDBUSY[p]                  = busy_q[ra];
            end
         end
      end
   end

   assign READY = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a default instance and a small ZERO_REG=0 instance.
// A driver updates an abstract register-file model and queues the expected
// outputs each cycle; a monitor pops and compares them on the falling edge.
module tb_reg_file_sb;

   typedef struct packed {
      logic              sel;
      logic              ready;
      logic [3:0][31:0]  data;
      logic [3:0]        busy;
      logic [2:0]        nrd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a, rst_b;
   logic        wr, iss;
   logic [4:0]  wa, ia;
   logic [31:0] wd;
   logic [4:0]  ra [4];

   logic [9:0]  ra_a;
   logic [63:0] rd_a;
   logic [1:0]  rb_a;
   logic        rdy_a;
   logic [8:0]  ra_b;
   logic [47:0] rd_b;
   logic [2:0]  rb_b;
   logic        rdy_b;

   always #5 clk = ~clk;

   always_comb begin
      ra_a = {ra[1], ra[0]};
      ra_b = {ra[2][2:0], ra[1][2:0], ra[0][2:0]};
   end

   reg_file_sb dut_a (
      .CLOCK(clk), .RESET(rst_a), .WRITE(wr), .INADDRESS(wa), .IN(wd),
      .ISSUE(iss), .ISSUEADDR(ia), .RDADDR(ra_a), .RDDATA(rd_a),
      .RDBUSY(rb_a), .READY(rdy_a)
   );

   reg_file_sb #(.DATA_W(16), .ADDR_W(3), .N_RD(3), .ZERO_REG(0)) dut_b (
      .CLOCK(clk), .RESET(rst_b), .WRITE(wr), .INADDRESS(wa[2:0]), .IN(wd[15:0]),
      .ISSUE(iss), .ISSUEADDR(ia[2:0]), .RDADDR(ra_b), .RDDATA(rd_b),
      .RDBUSY(rb_b), .READY(rdy_b)
   );

   // Reference model: plain arrays plus a countdown of remaining sweep edges.
   logic        m_sel;
   int          m_depth, m_nrd, m_left;
   bit          m_zero, m_init;
   logic [31:0] m_mask;
   logic [31:0] m_mem [32];
   bit          m_busy [32];

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Queue the expected outputs for the current inputs, then move to the falling edge.
   task automatic peek();
      exp_t e;
      if (m_init) begin
         e       = '0;
         e.sel   = m_sel;
         e.ready = (m_left == 0);
         e.nrd   = 3'(m_nrd);
         for (int p = 0; p < m_nrd; p++) begin
            int a;
            a = int'(ra[p]);
            if (!e.ready || (m_zero && a == 0)) begin
               e.data[p] = '0;
               e.busy[p] = 1'b0;
            end else if (wr && int'(wa) == a) begin
               e.data[p] = wd & m_mask;
               e.busy[p] = 1'b0;
            end else begin
               e.data[p] = m_mem[a];
               e.busy[p] = m_busy[a];
            end
         end
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   // Advance the model across the rising edge.
   task automatic tick();
      logic r;
      @(posedge clk);
      r = m_sel ? rst_b : rst_a;
      if (r) begin
         m_init = 1'b1;
         m_left = m_depth;
         for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (m_init) begin
         if (m_left > 0) begin
            m_mem[m_depth - m_left] = '0;
            m_left--;
         end else begin
            if (wr && !(m_zero && wa == 0)) begin
               m_mem[wa]  = wd & m_mask;
               m_busy[wa] = 1'b0;
            end
            if (iss && !(m_zero && ia == 0)) m_busy[ia] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic cycle();
      peek();
      tick();
   endtask

   task automatic idle();
      wr = 1'b0; iss = 1'b0; wa = '0; ia = '0; wd = '0;
      for (int p = 0; p < 4; p++) ra[p] = '0;
   endtask

   task automatic rand_cycles(input int n, input bit use_b);
      for (int i = 0; i < n; i++) begin
         if (use_b) rst_b = ($urandom_range(0, 63) == 0);
         else       rst_a = ($urandom_range(0, 63) == 0);
         wr  = 1'($urandom_range(0, 1));
         iss = ($urandom_range(0, 2) == 0);
         wa  = 5'($urandom_range(0, m_depth - 1));
         ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, m_depth - 1));
         wd  = $urandom;
         for (int p = 0; p < 4; p++)
            ra[p] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, m_depth - 1));
         cycle();
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
   endtask

   // Monitor: compares every queued expectation against the DUT it refers to.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("ready", 32'(e.sel ? rdy_b : rdy_a), 32'(e.ready));
            for (int p = 0; p < int'(e.nrd); p++) begin
               chk($sformatf("rddata[%0d]", p),
                   e.sel ? 32'(rd_b[p*16 +: 16]) : rd_a[p*32 +: 32], e.data[p]);
               chk($sformatf("rdbusy[%0d]", p),
                   32'(e.sel ? rb_b[p] : rb_a[p]), 32'(e.busy[p]));
            end
         end
      end
   end

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      idle();
      m_sel = 1'b0; m_depth = 32; m_nrd = 2; m_zero = 1'b1; m_mask = 32'hFFFF_FFFF;
      m_init = 1'b0; m_left = 0;
      for (int i = 0; i < 32; i++) begin m_mem[i] = '0; m_busy[i] = 1'b0; end
      @(posedge clk); #1;

      // Reset sweep on the default instance.
      cycle();
      rst_a = 1'b0;
      for (int i = 0; i < 32; i++) begin
         peek(); chk("sweep_not_ready", 32'(rdy_a), 32'd0); tick();
      end
      peek(); chk("sweep_ready", 32'(rdy_a), 32'd1); tick();

      // Write then read back on both ports; register 0 ignores writes.
      wr = 1'b1; wa = 5'd2; wd = 32'd95; cycle();
      idle(); ra[0] = 5'd2; ra[1] = 5'd2;
      peek(); chk("x2_p0", rd_a[31:0], 32'd95); chk("x2_p1", rd_a[63:32], 32'd95); tick();
      wr = 1'b1; wa = 5'd0; wd = 32'd7; cycle();
      idle();
      peek(); chk("x0_reads_zero", rd_a[31:0], 32'd0); tick();

      // Same-cycle bypass.
      wr = 1'b1; wa = 5'd1; wd = 32'd28; ra[0] = 5'd1;
      peek(); chk("bypass_data", rd_a[31:0], 32'd28); chk("bypass_busy", 32'(rb_a[0]), 32'd0); tick();

      // Scoreboard set, clear, and issue+write to the same index.
      idle(); iss = 1'b1; ia = 5'd4; cycle();
      idle(); ra[1] = 5'd4;
      peek(); chk("x4_busy", 32'(rb_a[1]), 32'd1); tick();
      wr = 1'b1; wa = 5'd4; wd = 32'd6; cycle();
      wr = 1'b0;
      peek(); chk("x4_cleared", 32'(rb_a[1]), 32'd0); chk("x4_data", rd_a[63:32], 32'd6); tick();
      iss = 1'b1; ia = 5'd4; wr = 1'b1; wa = 5'd4; wd = 32'd9; cycle();
      idle(); ra[1] = 5'd4;
      peek(); chk("x4_new_producer", 32'(rb_a[1]), 32'd1); tick();

      // Reset mid-sweep restarts the 32-edge sweep and discards busy bits.
      rst_a = 1'b1; cycle();
      rst_a = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      rst_a = 1'b1; cycle();
      rst_a = 1'b0;
      for (int i = 0; i < 32; i++) begin
         peek(); chk("resweep_not_ready", 32'(rdy_a), 32'd0); tick();
      end
      peek();
      chk("resweep_ready", 32'(rdy_a), 32'd1);
      chk("resweep_busy_x4", 32'(rb_a[1]), 32'd0);
      chk("resweep_data_x4", rd_a[63:32], 32'd0);
      tick();

      rand_cycles(400, 1'b0);

      // Small instance: 8-entry, three ports, register 0 writable.
      idle();
      rst_a = 1'b1;
      m_sel = 1'b1; m_depth = 8; m_nrd = 3; m_zero = 1'b0; m_mask = 32'h0000_FFFF;
      m_init = 1'b0;
      rst_b = 1'b1; cycle();
      rst_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         peek(); chk("b_sweep_not_ready", 32'(rdy_b), 32'd0); tick();
      end
      wr = 1'b1; wa = 5'd0; wd = 32'h1234;
      peek(); chk("b_ready", 32'(rdy_b), 32'd1); tick();
      idle();
      peek(); chk("b_x0_readback", 32'(rd_b[15:0]), 32'h1234); chk("b_x0_p2", 32'(rd_b[47:32]), 32'h1234); tick();

      rand_cycles(300, 1'b1);

      idle();
      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2^ADDR_W registers.
REQ-003 The block SHALL have parameter N_RD, default 2, number of independent read ports (1..4).
REQ-004 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 reads 0, is never written and is never busy.
REQ-005 The block SHALL have port CLOCK  in  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port RESET  in  1  reset, synchronous, active-high.
REQ-007 The block SHALL have port WRITE  in  1  write-back enable.
REQ-008 The block SHALL have port INADDRESS  in  ADDR_W  write-back register index.
REQ-009 The block SHALL have port IN  in  DATA_W  write-back data.
REQ-010 The block SHALL have port ISSUE  in  1  marks INSSUEADDR as pending destination of an issued instruction.
REQ-011 The block SHALL have port ISSUEADDR  in  ADDR_W  destination index of issued instruction.
REQ-012 The block SHALL have port RDADDR  in  N_RD*ADDR_W  packed read indices, port p at bits [p*ADDR_W +: ADDR_W].
REQ-013 The block SHALL have port RDDATA  out  N_RD*DATA_W  packed read data, same packing.
REQ-014 The block SHALL have port RDBUSY  out  N_RD  per-port "operand not yet written back" flag.
REQ-015 The block SHALL have port READY  out  1  high when the clear sweep is complete and the file is usable.

Function
REQ-016 Reads SHALL be combinational: RDDATA[p] = mem[RDADDR[p]], zero latency.
REQ-017 Write bypass: if WRITE=1, READY=1, INADDRESS=RDADDR[p] (and nonzero when ZERO_REG=1), RDDATA[p] SHALL equal IN in the same cycle.
REQ-018 A write SHALL update mem[INADDRESS] at the rising edge when WRITE=1 and READY=1; writes to index 0 with ZERO_REG=1 are dropped.
REQ-019 Scoreboard: one busy bit per register; ISSUE=1 with READY=1 SHALL set busy[ISSUEADDR] at the edge.
REQ-020 WRITE=1 with READY=1 SHALL clear busy[INADDRESS] at the edge.
REQ-021 Simultaneous ISSUE and WRITE to the same index SHALL leave busy set (new producer wins).
REQ-022 ISSUE to an already-busy index SHALL leave it busy (no count, no error).
REQ-023 RDBUSY[p] SHALL be busy[RDADDR[p]] AND NOT (same-cycle bypassing write per REQ-017); always 0 for index 0 when ZERO_REG=1.
REQ-024 Multiple read ports addressing the same index SHALL return identical data and busy.
REQ-025 While READY=0: WRITE and ISSUE SHALL be ignored, RDDATA SHALL be 0, RDBUSY SHALL be 0.

Reset
REQ-026 An edge with RESET=1 SHALL set sweep pointer to 0, READY to 0, all busy bits to 0.
REQ-027 Each subsequent edge with RESET=0 and READY=0 SHALL write mem[ptr]<=0 and ptr<=ptr+1.
REQ-028 The edge clearing mem[DEPTH-1] SHALL set READY<=1; READY therefore rises DEPTH edges after the last RESET-high edge.
REQ-029 RESET asserted mid-sweep or mid-operation SHALL restart the sweep from index 0 and discard pending busy bits.
REQ-030 Register contents before the first reset are undefined; outputs are defined only as in REQ-025 after the first RESET edge.

Verification
REQ-031 Reset sweep: RESET 1 edge, then low -> READY=0 for 32 edges, READY=1 after 32nd; all RDDATA=0 then.
REQ-032 Write/read: WRITE x2=95 at edge, next cycle RDADDR={2,2} -> RDDATA both 95; x0 write of 7 -> reads 0.
REQ-033 Bypass: WRITE x1=28 with RDADDR[0]=1 same cycle -> RDDATA[0]=28 before edge, RDBUSY[0]=0.
REQ-034 Scoreboard: ISSUE x4, next cycle RDADDR[1]=4 -> RDBUSY[1]=1; WRITE x4=6 -> clears; ISSUE+WRITE x4 same edge -> still busy.
REQ-035 Reset mid-sweep: RESET at sweep edge 10 -> READY delayed to 32 edges after new release; busy x4 cleared.
REQ-036 Parameter sweep: DATA_W=16, ADDR_W=3, N_RD=3, ZERO_REG=0 -> READY after 8 edges, x0 writable (value 0x1234 read back).
